// File: rtl/pir_level_encoder.sv
// pir_level_encoder: synchronises three PIR outputs and publishes per-window high-time levels with warm-up and peak-hold.
module pir_level_encoder #(
    parameter int WINDOW_CYCLES  = 100,
    parameter int THRESHOLD      = 50,
    parameter int HOLD_WINDOWS   = 3,
    parameter int WARMUP_WINDOWS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [2:0] pir_raw,
    output logic [6:0] pir_sensor_1,
    output logic [6:0] pir_sensor_2,
    output logic [6:0] pir_sensor_3,
    output logic       level_valid,
    output logic [2:0] active
);
    localparam logic [1:0] OFF    = 2'd0;
    localparam logic [1:0] WARMUP = 2'd1;
    localparam logic [1:0] RUN    = 2'd2;
    localparam logic [6:0] TH     = 7'(THRESHOLD);
    logic [1:0] state;
    logic [2:0] s1, s;
    logic [6:0] win_cnt;
    logic [3:0] warm_cnt;
    logic [6:0] high_cnt[3];
    logic [3:0] hold_cnt[3];
    logic [6:0] level[3];
    logic [6:0] m[3];
    logic [6:0] nxt_level[3];
    logic [3:0] nxt_hold[3];
    logic       win_end;
    assign win_end = win_cnt == 7'(WINDOW_CYCLES - 1);
    assign pir_sensor_1 = level[0];
    assign pir_sensor_2 = level[1];
    assign pir_sensor_3 = level[2];
    // m includes the sample taken at the window-end edge itself
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            m[i] = high_cnt[i] + 7'(s[i]);
            nxt_level[i] = m[i] >= TH ? ((hold_cnt[i] != 4'd0 && level[i] > m[i]) ? level[i] : m[i])
                                      : (hold_cnt[i] != 4'd0 ? level[i] : m[i]);
            nxt_hold[i] = m[i] >= TH ? 4'(HOLD_WINDOWS) : (hold_cnt[i] != 4'd0 ? hold_cnt[i] - 4'd1 : 4'd0);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= OFF;
            s1          <= '0;
            s           <= '0;
            win_cnt     <= '0;
            warm_cnt    <= '0;
            level_valid <= 1'b0;
            active      <= '0;
            for (int i = 0; i < 3; i++) begin
                high_cnt[i] <= '0;
                hold_cnt[i] <= '0;
                level[i]    <= '0;
            end
        end else begin
            s1          <= pir_raw;
            s           <= s1;
            level_valid <= 1'b0;
            if (!enable) begin
                state    <= OFF;
                win_cnt  <= '0;
                warm_cnt <= '0;
                active   <= '0;
                for (int i = 0; i < 3; i++) begin
                    high_cnt[i] <= '0;
                    hold_cnt[i] <= '0;
                    level[i]    <= '0;
                end
            end else if (state == OFF) begin
                state    <= WARMUP_WINDOWS == 0 ? RUN : WARMUP;
                win_cnt  <= '0;
                warm_cnt <= '0;
            end else begin
                win_cnt <= win_end ? 7'd0 : win_cnt + 7'd1;
                if (state == WARMUP) begin
                    if (win_end) begin
                        warm_cnt <= warm_cnt + 4'd1;
                        if (warm_cnt == 4'(WARMUP_WINDOWS - 1)) state <= RUN;
                    end
                end else begin
                    for (int i = 0; i < 3; i++) high_cnt[i] <= win_end ? 7'd0 : m[i];
                    if (win_end) begin
                        level_valid <= 1'b1;
                        for (int i = 0; i < 3; i++) begin
                            level[i]    <= nxt_level[i];
                            hold_cnt[i] <= nxt_hold[i];
                            active[i]   <= nxt_level[i] >= TH;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_pir_level_encoder.sv
// tb_pir_level_encoder: random PIR duty patterns, enable drops and resets checked against a window-arithmetic model.
module tb_pir_level_encoder;
    localparam int W = 100, TH = 50, HOLD = 3, WARM = 2;
    logic       clk = 1'b0, rst = 1'b1, enable = 1'b0;
    logic [2:0] pir_raw = '0;
    logic [6:0] pir_sensor_1, pir_sensor_2, pir_sensor_3;
    logic       level_valid;
    logic [2:0] active;
    int checks = 0, errors = 0;
    pir_level_encoder #(.WINDOW_CYCLES(W), .THRESHOLD(TH), .HOLD_WINDOWS(HOLD), .WARMUP_WINDOWS(WARM)) dut (
        .clk(clk), .rst(rst), .enable(enable), .pir_raw(pir_raw),
        .pir_sensor_1(pir_sensor_1), .pir_sensor_2(pir_sensor_2), .pir_sensor_3(pir_sensor_3),
        .level_valid(level_valid), .active(active)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask
    // reference: edges counted from the enabling edge; samples seen 2 edges after the raw value
    int m_level[3], m_hold[3], m_sum[3];
    int m_t;
    bit m_on, m_valid;
    logic [2:0] dq[$];
    task automatic model_edge(input bit r, input bit en, input logic [2:0] raw);
        logic [2:0] samp;
        m_valid = 1'b0;
        if (r) begin
            dq = {3'b000, 3'b000};
            m_on = 1'b0;
            m_t = 0;
            for (int i = 0; i < 3; i++) begin m_level[i] = 0; m_hold[i] = 0; m_sum[i] = 0; end
            return;
        end
        dq.push_back(raw);
        samp = dq.pop_front();
        if (!en) begin
            m_on = 1'b0;
            m_t = 0;
            for (int i = 0; i < 3; i++) begin m_level[i] = 0; m_hold[i] = 0; m_sum[i] = 0; end
        end else if (!m_on) begin
            m_on = 1'b1;
            m_t = 0;
            for (int i = 0; i < 3; i++) m_sum[i] = 0;
        end else begin
            m_t++;
            if (m_t > WARM * W) begin
                for (int i = 0; i < 3; i++) m_sum[i] += samp[i];
                if (m_t % W == 0) begin
                    m_valid = 1'b1;
                    for (int i = 0; i < 3; i++) begin
                        if (m_sum[i] >= TH) begin
                            if (m_hold[i] == 0 || m_sum[i] > m_level[i]) m_level[i] = m_sum[i];
                            m_hold[i] = HOLD;
                        end else if (m_hold[i] > 0) m_hold[i]--;
                        else m_level[i] = m_sum[i];
                        m_sum[i] = 0;
                    end
                end
            end
        end
    endtask
    initial begin
        int duty[3];
        bit noise[3];
        int bc = 0, off_left = 0;
        dq = {3'b000, 3'b000};
        for (int i = 0; i < 3; i++) begin duty[i] = 0; noise[i] = 1'b0; end
        for (int cyc = 0; cyc < 30000; cyc++) begin
            @(posedge clk);
            model_edge(rst, enable, pir_raw);
            #1;
            check("level_valid", int'(level_valid), int'(m_valid));
            check("pir_sensor_1", int'(pir_sensor_1), m_level[0]);
            check("pir_sensor_2", int'(pir_sensor_2), m_level[1]);
            check("pir_sensor_3", int'(pir_sensor_3), m_level[2]);
            check("active", int'(active), {29'd0, m_level[2] >= TH, m_level[1] >= TH, m_level[0] >= TH});
            rst = (cyc < 2) || ($urandom_range(0, 3999) == 0);
            if (off_left > 0) begin
                off_left--;
                enable = 1'b0;
            end else if (cyc > 3 && $urandom_range(0, 1499) == 0) begin
                off_left = $urandom_range(0, 20);
                enable = 1'b0;
            end else enable = cyc >= 3;
            if (bc == 0) begin
                for (int i = 0; i < 3; i++) begin
                    case ($urandom_range(0, 7))
                        0: duty[i] = 0;
                        1: duty[i] = W;
                        2: duty[i] = TH + $urandom_range(0, 1) - 1;
                        default: duty[i] = $urandom_range(0, W);
                    endcase
                    noise[i] = $urandom_range(0, 7) == 0;
                end
            end
            for (int i = 0; i < 3; i++) pir_raw[i] = noise[i] ? 1'($urandom_range(0, 1)) : (bc < duty[i]);
            bc = (bc + 1) % W;
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pir_level_encoder.md
Name: pir_level_encoder

Overview:
- Sensor-side front end that produces the 7-bit PIR intensity words consumed by the motion-alarm controller (pir_sensor_1..3).
- Takes the three raw asynchronous 1-bit PIR outputs, synchronises them, and measures each channel's high-time per fixed window.
- Applies a post-power-on warm-up and a per-channel peak-hold (retrigger) stage.
- Publishes registered levels with a one-cycle level_valid strobe per window.

Parameters:
- WINDOW_CYCLES, 100, samples per measurement window; legal range 1..127 so a level fits 7 bits.
- THRESHOLD, 50, level at or above which a channel counts as triggered and arms hold.
- HOLD_WINDOWS, 3, number of subsequent below-threshold windows for which a triggered level is held; legal range 0..15.
- WARMUP_WINDOWS, 2, windows discarded after enable rises; legal range 0..15.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  system on/off, same role as the controller's turn.
- pir_raw  input  3  raw asynchronous PIR outputs; bit0 is channel 1, bit2 is channel 3.
- pir_sensor_1  output  7  channel-1 level, 0..WINDOW_CYCLES.
- pir_sensor_2  output  7  channel-2 level.
- pir_sensor_3  output  7  channel-3 level.
- level_valid  output  1  one-cycle strobe when levels update.
- active  output  3  active[i] = (level of channel i+1 >= THRESHOLD).

Behaviour:
- Reset
  - rst sampled high: all outputs 0; win_cnt, high_cnt[3], hold_cnt[3], warm_cnt and synchronisers cleared; state OFF.
  - rst has priority over everything.
- Synchroniser: two flops per channel. Counting uses the second-stage bit s[i], giving 2 cycles of latency from a raw edge.
- States: OFF, WARMUP, RUN.
- OFF
  - Outputs held 0; all counters held 0.
  - enable=1 sampled at edge E0: enter WARMUP (or RUN if WARMUP_WINDOWS=0), win_cnt=0.
- Window counter (WARMUP and RUN)
  - Each edge samples s[i] and increments win_cnt.
  - At the edge where win_cnt == WINDOW_CYCLES-1 ("window end"), win_cnt wraps to 0 and high_cnt clears.
  - Each window is exactly WINDOW_CYCLES samples.
- WARMUP
  - high_cnt ignored; no level_valid.
  - warm_cnt counts window ends.
  - On the WARMUP_WINDOWS-th window end: enter RUN with win_cnt=0 and high_cnt=0.
- RUN
  - high_cnt[i] += s[i] each edge.
  - At window end: m[i] = high_cnt[i] + s[i], giving the current edge's sample.
  - At that same edge, register per channel:
    - if m >= THRESHOLD: level <= (hold_cnt != 0) ? max(level, m) : m; hold_cnt <= HOLD_WINDOWS.
    - else if hold_cnt != 0: level unchanged; hold_cnt <= hold_cnt-1.
    - else: level <= m.
  - Also at that edge: level_valid <= 1 for exactly one cycle; active updated from the new levels.
- enable low in WARMUP/RUN: next edge goes to OFF with all outputs and counters 0; no partial-window level is published. Re-enable repeats the full warm-up.
- Width rules
  - high_cnt is 7 bits and never exceeds WINDOW_CYCLES.
  - max() is unsigned.
  - hold_cnt is 4 bits.
- Simultaneous events
  - Window end coincident with enable falling: OFF wins, no strobe.
  - Window end coincident with rst: reset wins.
- Level outputs change only at window-end edges or on entry to OFF.

Test Plan:
1. rst, then enable=1 at E0 with pir_raw=000, defaults → no level_valid until the single strobe following edge E0+300; all levels 0, active=000.
2. pir_raw[0] held 1 from before E0 → first strobe gives pir_sensor_1=100, others 0, active=001; repeats every 100 cycles.
3. pir_raw[1] periodic (high 60, low 40) phase-locked to windows → pir_sensor_2=60 every strobe, active=010.
4. Channel 3: one window at 80, then windows at 0 → pir_sensor_3=80 on that strobe and the next 3 strobes, 0 on the 4th; active[2] drops with it.
5. Channel 1 peak-hold: windows of 55, 90, 30, 70 → outputs 55, 90, 90, 90; hold re-armed by the 70 window.
6. enable dropped mid-window in RUN (and separately rst high) → next cycle all levels 0, level_valid 0, state OFF; re-enable gives the first strobe again 300 cycles later.
